// File: rtl/sequenciador_posicionamento.sv
// Ship-placement sequencer: walks both players through 11 ships each, latches the
// confirmed coordinates and hands one placement at a time to the Validador.
module sequenciador_posicionamento #(
    parameter int N_NAVIOS = 11,
    parameter int TAM_TAB  = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       confirma,
    input  logic [3:0] x_in,
    input  logic [3:0] y_in,
    input  logic       direcao_in,
    input  logic [2:0] orientacao_in,
    input  logic       ready,
    input  logic       conflito,
    output logic       enable,
    output logic [2:0] tipo,
    output logic       direcao,
    output logic [2:0] orientacao,
    output logic [3:0] x1,
    output logic [3:0] y1,
    output logic       jogador,
    output logic [3:0] indice_navio,
    output logic       erro,
    output logic       concluido,
    output logic       falha
);

    localparam int         CW        = $clog2(TIMEOUT + 1);
    localparam logic [3:0] LIM_COORD = 4'(TAM_TAB);
    localparam logic [3:0] ULTIMO    = 4'(N_NAVIOS - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        AGUARDA   = 3'd1,
        VALIDA    = 3'd2,
        CONCLUIDO = 3'd3,
        FALHA     = 3'd4
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          enable_q, enable_d;
    logic [2:0]    tipo_q, tipo_d;
    logic          direcao_q, direcao_d;
    logic [2:0]    orientacao_q, orientacao_d;
    logic [3:0]    x1_q, x1_d;
    logic [3:0]    y1_q, y1_d;
    logic          jogador_q, jogador_d;
    logic [3:0]    indice_q, indice_d;
    logic          erro_q, erro_d;
    logic          concluido_q, concluido_d;
    logic          falha_q, falha_d;
    logic          faixa_ok_s;

    // Fleet composition: five 000, two 001, two 010, one 011, one 100.
    function automatic logic [2:0] tipo_de(input logic [3:0] idx);
        logic [2:0] t;
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: t = 3'b000;
            4'd5, 4'd6:                   t = 3'b001;
            4'd7, 4'd8:                   t = 3'b010;
            4'd9:                         t = 3'b011;
            4'd10:                        t = 3'b100;
            default:                      t = 3'b000;
        endcase
        return t;
    endfunction

    assign faixa_ok_s = (x_in < LIM_COORD) && (y_in < LIM_COORD) && (orientacao_in <= 3'd3);

    // Next-state and next-output computation for the placement sequence.
    always_comb begin
        estado_d     = estado_q;
        cnt_d        = cnt_q;
        enable_d     = enable_q;
        tipo_d       = tipo_q;
        direcao_d    = direcao_q;
        orientacao_d = orientacao_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        jogador_d    = jogador_q;
        indice_d     = indice_q;
        erro_d       = 1'b0;
        concluido_d  = concluido_q;
        falha_d      = falha_q;
        case (estado_q)
            OCIOSO: begin
                if (start) begin
                    estado_d  = AGUARDA;
                    jogador_d = 1'b0;
                    indice_d  = 4'd0;
                    tipo_d    = tipo_de(4'd0);
                end else begin
                    estado_d = OCIOSO;
                end
            end
            AGUARDA: begin
                if (confirma && !faixa_ok_s) begin
                    erro_d = 1'b1;
                end else if (confirma) begin
                    x1_d         = x_in;
                    y1_d         = y_in;
                    // Only non-000 ships have a direction; only 010 (hidroaviao) rotates.
                    direcao_d    = (tipo_q == 3'b000) ? 1'b0 : direcao_in;
                    orientacao_d = (tipo_q == 3'b010) ? orientacao_in : 3'd0;
                    enable_d     = 1'b1;
                    cnt_d        = '0;
                    estado_d     = VALIDA;
                end else begin
                    estado_d = AGUARDA;
                end
            end
            VALIDA: begin
                if (ready && conflito) begin
                    enable_d = 1'b0;
                    erro_d   = 1'b1;
                    estado_d = AGUARDA;
                end else if (ready) begin
                    enable_d = 1'b0;
                    if (indice_q != ULTIMO) begin
                        indice_d = indice_q + 4'd1;
                        tipo_d   = tipo_de(indice_q + 4'd1);
                        estado_d = AGUARDA;
                    end else if (!jogador_q) begin
                        jogador_d = 1'b1;
                        indice_d  = 4'd0;
                        tipo_d    = tipo_de(4'd0);
                        estado_d  = AGUARDA;
                    end else begin
                        concluido_d = 1'b1;
                        estado_d    = CONCLUIDO;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    enable_d = 1'b0;
                    falha_d  = 1'b1;
                    estado_d = FALHA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CONCLUIDO, FALHA: begin
                if (start) begin
                    concluido_d = 1'b0;
                    falha_d     = 1'b0;
                    jogador_d   = 1'b0;
                    indice_d    = 4'd0;
                    tipo_d      = tipo_de(4'd0);
                    estado_d    = AGUARDA;
                end else begin
                    estado_d = estado_q;
                end
            end
            default: begin
                estado_d = OCIOSO;
                enable_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops enable without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= OCIOSO;
            cnt_q        <= '0;
            enable_q     <= 1'b0;
            tipo_q       <= 3'b000;
            direcao_q    <= 1'b0;
            orientacao_q <= 3'd0;
            x1_q         <= 4'd0;
            y1_q         <= 4'd0;
            jogador_q    <= 1'b0;
            indice_q     <= 4'd0;
            erro_q       <= 1'b0;
            concluido_q  <= 1'b0;
            falha_q      <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            enable_q     <= enable_d;
            tipo_q       <= tipo_d;
            direcao_q    <= direcao_d;
            orientacao_q <= orientacao_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            jogador_q    <= jogador_d;
            indice_q     <= indice_d;
            erro_q       <= erro_d;
            concluido_q  <= concluido_d;
            falha_q      <= falha_d;
        end
    end

    assign enable       = enable_q;
    assign tipo         = tipo_q;
    assign direcao      = direcao_q;
    assign orientacao   = orientacao_q;
    assign x1           = x1_q;
    assign y1           = y1_q;
    assign jogador      = jogador_q;
    assign indice_navio = indice_q;
    assign erro         = erro_q;
    assign concluido    = concluido_q;
    assign falha        = falha_q;

endmodule
